// File: rtl/pe_operand_sequencer_pkg.sv
// Shared types, default geometry and precision helper for the PE operand sequencer.
package pe_operand_sequencer_pkg;

    localparam int A_WIDTH_DEF = 8;
    localparam int B_WIDTH_DEF = 8;
    localparam int SLICE_W_DEF = 2;

    localparam int NA   = A_WIDTH_DEF / SLICE_W_DEF;
    localparam int NB   = B_WIDTH_DEF / SLICE_W_DEF;
    localparam int PA_W = $clog2(NA) + 1;
    localparam int PB_W = $clog2(NB) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Zero means "one slice"; anything above the operand's slice count saturates.
    function automatic int clamp_prec(input int prec, input int max_prec);
        if (prec < 1) return 1;
        if (prec > max_prec) return max_prec;
        return prec;
    endfunction

endpackage

// File: rtl/pe_operand_sequencer_slice_sel.sv
// Picks slice number idx (SLICE_W bits wide) out of an unsigned operand.
module bitbrick_slice_sel #(
    parameter int OP_W    = 8,
    parameter int SLICE_W = 2,
    parameter int IDX_W   = 3
) (
    input  logic [OP_W-1:0]    operand,
    input  logic [IDX_W-1:0]   idx,
    output logic [SLICE_W-1:0] slice
);

    assign slice = SLICE_W'(operand >> (int'(idx) * SLICE_W));

endmodule

// File: rtl/pe_operand_sequencer.sv
// Splits accepted operand pairs into slice products and drives one PE per cycle,
// flagging the cycle in which the PE accumulator holds a finished group result.
module pe_operand_sequencer
    import pe_operand_sequencer_pkg::*;
#(
    parameter int A_WIDTH     = A_WIDTH_DEF,
    parameter int B_WIDTH     = B_WIDTH_DEF,
    parameter int SLICE_W     = SLICE_W_DEF,
    parameter int ACC_WIDTH   = 16,
    parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PA_W-1:0]        cfg_prec_a,
    input  logic [PB_W-1:0]        cfg_prec_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [A_WIDTH-1:0]     in_a,
    input  logic [B_WIDTH-1:0]     in_b,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic [SLICE_W-1:0]     pe_in_0,
    output logic [SLICE_W-1:0]     pe_in_1,
    output logic [SHIFT_WIDTH-1:0] pe_shift,
    output logic                   pe_sel,
    output logic                   pe_valid,
    output logic                   res_valid,
    output logic                   busy
);

    if (A_WIDTH + B_WIDTH - 2 * SLICE_W >= ACC_WIDTH) begin : g_acc_check
        $error("ACC_WIDTH too narrow for the largest shifted slice product");
    end

    state_t                 state_q, state_d;
    logic [A_WIDTH-1:0]     a_q, a_d;
    logic [B_WIDTH-1:0]     b_q, b_d;
    logic                   last_q, last_d;
    logic [PA_W-1:0]        pa_q, pa_d, i_q, i_d;
    logic [PB_W-1:0]        pb_q, pb_d, j_q, j_d;
    logic [SLICE_W-1:0]     pe_in_0_q, pe_in_0_d, pe_in_1_q, pe_in_1_d;
    logic [SHIFT_WIDTH-1:0] pe_shift_q, pe_shift_d;
    logic                   pe_sel_q, pe_sel_d;
    logic                   pe_valid_q, pe_valid_d;
    logic                   res_valid_q, res_valid_d;
    logic [SLICE_W-1:0]     slice_a, slice_b;
    logic                   final_slice, accept;

    assign final_slice = (state_q == ISSUE) && (i_q == pa_q - PA_W'(1)) && (j_q == pb_q - PB_W'(1));
    assign in_ready    = (state_q == IDLE) || final_slice;
    assign accept      = in_valid && in_ready;

    // Slices are selected from the next-state operand/index so every pe_* output is a flop.
    bitbrick_slice_sel #(.OP_W(A_WIDTH), .SLICE_W(SLICE_W), .IDX_W(PA_W)) u_sel_a (
        .operand(a_d), .idx(i_d), .slice(slice_a)
    );
    bitbrick_slice_sel #(.OP_W(B_WIDTH), .SLICE_W(SLICE_W), .IDX_W(PB_W)) u_sel_b (
        .operand(b_d), .idx(j_d), .slice(slice_b)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        last_d     = last_q;
        pa_d       = pa_q;
        pb_d       = pb_q;
        i_d        = i_q;
        j_d        = j_q;
        pe_valid_d = 1'b0;
        pe_sel_d   = 1'b1;

        if (accept) begin
            a_d        = in_a;
            b_d        = in_b;
            last_d     = in_last;
            i_d        = '0;
            j_d        = '0;
            pe_valid_d = 1'b1;
            pe_sel_d   = ~in_first;
            state_d    = ISSUE;
            if (in_first) begin
                pa_d = PA_W'(clamp_prec(int'(cfg_prec_a), NA));
                pb_d = PB_W'(clamp_prec(int'(cfg_prec_b), NB));
            end
        end else if ((state_q == ISSUE) && !final_slice) begin
            pe_valid_d = 1'b1;
            if (j_q == pb_q - PB_W'(1)) begin
                j_d = '0;
                i_d = i_q + PA_W'(1);
            end else begin
                j_d = j_q + PB_W'(1);
            end
        end else begin
            state_d = IDLE;
        end

        // The PE has no enable: idle cycles must present a zero product in accumulate mode.
        pe_in_0_d   = pe_valid_d ? slice_a : '0;
        pe_in_1_d   = pe_valid_d ? slice_b : '0;
        pe_shift_d  = pe_valid_d ? SHIFT_WIDTH'((int'(i_d) + int'(j_d)) * SLICE_W) : '0;
        res_valid_d = final_slice && last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b0;
            pa_q        <= PA_W'(NA);
            pb_q        <= PB_W'(NB);
            i_q         <= '0;
            j_q         <= '0;
            pe_in_0_q   <= '0;
            pe_in_1_q   <= '0;
            pe_shift_q  <= '0;
            pe_sel_q    <= 1'b1;
            pe_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            pa_q        <= pa_d;
            pb_q        <= pb_d;
            i_q         <= i_d;
            j_q         <= j_d;
            pe_in_0_q   <= pe_in_0_d;
            pe_in_1_q   <= pe_in_1_d;
            pe_shift_q  <= pe_shift_d;
            pe_sel_q    <= pe_sel_d;
            pe_valid_q  <= pe_valid_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign pe_in_0   = pe_in_0_q;
    assign pe_in_1   = pe_in_1_q;
    assign pe_shift  = pe_shift_q;
    assign pe_sel    = pe_sel_q;
    assign pe_valid  = pe_valid_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == ISSUE);

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Directed + randomized bench for pe_operand_sequencer with a slice-schedule reference model
// and a behavioural multiply-shift-accumulate PE attached to the pe_* outputs.
module tb_pe_operand_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] cfg_prec_a, cfg_prec_b;
    logic       in_valid, in_ready, in_first, in_last;
    logic [7:0] in_a, in_b;
    logic [1:0] pe_in_0, pe_in_1;
    logic [3:0] pe_shift;
    logic       pe_sel, pe_valid, res_valid, busy;

    always #5 clk = ~clk;

    pe_operand_sequencer dut (
        .clk(clk), .reset(reset), .cfg_prec_a(cfg_prec_a), .cfg_prec_b(cfg_prec_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last), .pe_in_0(pe_in_0), .pe_in_1(pe_in_1),
        .pe_shift(pe_shift), .pe_sel(pe_sel), .pe_valid(pe_valid),
        .res_valid(res_valid), .busy(busy)
    );

    // Behavioural PE: load or accumulate the shifted slice product every cycle.
    logic [15:0] pe_acc = 16'd0;
    always @(posedge clk) begin
        if (pe_sel) pe_acc <= pe_acc + ((16'(pe_in_0) * 16'(pe_in_1)) << pe_shift);
        else        pe_acc <= (16'(pe_in_0) * 16'(pe_in_1)) << pe_shift;
    end

    typedef struct {
        int in0;
        int in1;
        int shift;
        bit sel;
        bit fin_last;
        int res_val;
    } rec_t;

    rec_t        exp_q[$];
    bit          res_pend;
    int          res_val_pend;
    int          cur_pa, cur_pb;
    logic [15:0] grp;
    int          tests, fails;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp4(input int p);
        return (p == 0) ? 1 : ((p > 4) ? 4 : p);
    endfunction

    // Reference: a pair of precision pa x pb becomes pa*pb slice products, A outer, B inner.
    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input bit f,
                                input bit l, input int cpa, input int cpb);
        int   pa, pb;
        int   am, bm;
        rec_t r;
        if (f) begin
            cur_pa = clamp4(cpa);
            cur_pb = clamp4(cpb);
        end
        pa = cur_pa;
        pb = cur_pb;
        am = int'(a) % (1 << (2 * pa));
        bm = int'(b) % (1 << (2 * pb));
        grp = f ? 16'(am * bm) : 16'(grp + 16'(am * bm));
        for (int i = 0; i < pa; i++) begin
            for (int j = 0; j < pb; j++) begin
                r.in0      = (int'(a) >> (2 * i)) % 4;
                r.in1      = (int'(b) >> (2 * j)) % 4;
                r.shift    = 2 * (i + j);
                r.sel      = !(f && i == 0 && j == 0);
                r.fin_last = l && (i == pa - 1) && (j == pb - 1);
                r.res_val  = int'(grp);
                exp_q.push_back(r);
            end
        end
    endtask

    // One clock cycle: present inputs, check this cycle's outputs at negedge, model the handshake.
    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b, input bit f,
                        input bit l, input int cpa, input int cpb, output bit accepted);
        bit   have, rdy;
        rec_t r;
        r = '{0, 0, 0, 1'b1, 1'b0, 0};
        in_valid = v; in_a = a; in_b = b; in_first = f; in_last = l;
        cfg_prec_a = 3'(cpa); cfg_prec_b = 3'(cpb);
        @(negedge clk);
        have = (exp_q.size() != 0);
        if (have) r = exp_q.pop_front();
        chk("pe_valid", 32'(pe_valid), 32'(have));
        chk("busy", 32'(busy), 32'(have));
        chk("pe_in_0", 32'(pe_in_0), have ? r.in0 : 0);
        chk("pe_in_1", 32'(pe_in_1), have ? r.in1 : 0);
        chk("pe_shift", 32'(pe_shift), have ? r.shift : 0);
        chk("pe_sel", 32'(pe_sel), 32'(have ? r.sel : 1'b1));
        chk("res_valid", 32'(res_valid), 32'(res_pend));
        if (res_pend) chk("pe_out_at_res", 32'(pe_acc), res_val_pend);
        res_pend     = have && r.fin_last;
        res_val_pend = r.res_val;
        rdy = (exp_q.size() == 0);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        accepted = v && rdy;
        if (accepted) model_accept(a, b, f, l, cpa, cpb);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4, 4, acc);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit f, input bit l,
                        input int cpa, input int cpb);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) step(1'b1, a, b, f, l, cpa, cpb, acc);
        if (!acc) chk("send_timeout", 32'(acc), 32'(1'b1));
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (exp_q.size() != 0 || res_pend); k++) idle(1);
        chk("drain_done", 32'(exp_q.size()), 0);
    endtask

    logic [7:0] xa[3], xb[3];
    int         exp4;
    int         pairs;
    logic [7:0] ra, rb;

    initial begin
        tests = 0; fails = 0; res_pend = 0; res_val_pend = 0;
        cur_pa = 4; cur_pb = 4; grp = '0;
        reset = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_first = 0; in_last = 0;
        cfg_prec_a = 3'd4; cfg_prec_b = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pe_valid", 32'(pe_valid), 0);
        chk("rst_pe_in_0", 32'(pe_in_0), 0);
        chk("rst_pe_in_1", 32'(pe_in_1), 0);
        chk("rst_pe_shift", 32'(pe_shift), 0);
        chk("rst_pe_sel", 32'(pe_sel), 1);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        reset = 1'b0;
        idle(2);

        // Full precision single-pair group: 183 * 92.
        send(8'hB7, 8'h5C, 1'b1, 1'b1, 4, 4);
        drain();
        chk("t1_pe_out", 32'(pe_acc), 16836);
        idle(2);

        // Precision 1/1, three pairs back to back.
        send(8'd3, 8'd2, 1'b1, 1'b0, 1, 1);
        send(8'd1, 8'd1, 1'b0, 1'b0, 1, 1);
        send(8'd2, 8'd3, 1'b0, 1'b1, 1, 1);
        drain();
        chk("t2_pe_out", 32'(pe_acc), 13);
        idle(2);

        // Precision 2/4; changing cfg mid-group must not matter.
        send(8'hFD, 8'd200, 1'b1, 1'b0, 2, 4);
        send(8'hFD, 8'd200, 1'b0, 1'b1, 1, 1);
        drain();
        chk("t3_pe_out", 32'(pe_acc), 5200);
        idle(2);

        // Same 3-pair group gap-free, then with 5 idle cycles between pairs.
        exp4 = 0;
        for (int k = 0; k < 3; k++) begin
            xa[k] = 8'($urandom);
            xb[k] = 8'($urandom);
            exp4 = exp4 + int'(xa[k]) * int'(xb[k]);
        end
        exp4 = exp4 % 65536;
        for (int k = 0; k < 3; k++) send(xa[k], xb[k], k == 0, k == 2, 4, 4);
        drain();
        chk("t4_gapfree", 32'(pe_acc), exp4);
        idle(2);
        for (int k = 0; k < 3; k++) begin
            send(xa[k], xb[k], k == 0, k == 2, 4, 4);
            if (k < 2) begin
                drain();
                idle(5);
            end
        end
        drain();
        chk("t4_gapped", 32'(pe_acc), exp4);
        idle(2);

        // Asynchronous reset in the middle of a pair.
        send(8'hA5, 8'h3C, 1'b1, 1'b1, 4, 4);
        idle(5);
        reset = 1'b1;
        #1;
        chk("mid_rst_pe_valid", 32'(pe_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pe_sel", 32'(pe_sel), 1);
        chk("mid_rst_pe_in_0", 32'(pe_in_0), 0);
        chk("mid_rst_pe_shift", 32'(pe_shift), 0);
        exp_q.delete();
        res_pend = 0; cur_pa = 4; cur_pb = 4;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(20);

        // Out-of-range precision: 0 acts as 1, 5 saturates to 4.
        ra = 8'($urandom);
        rb = 8'($urandom);
        send(ra, rb, 1'b1, 1'b1, 0, 5);
        drain();
        chk("t6_pe_out", 32'(pe_acc), int'(ra % 4) * int'(rb));
        idle(1);

        // Randomized traffic.
        pairs = 0;
        for (int k = 0; k < 40; k++) begin
            send(8'($urandom), 8'($urandom), (k == 0) || ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7));
            pairs++;
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();
        chk("rand_pairs", 32'(pairs), 40);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
